// File: rtl/exec_wb_stage.sv
// exec_wb_stage: execute/writeback stage feeding the regfile write port.
// Single-cycle ALU ops retire next cycle; MUL is an iterative shift-add unit.
`default_nettype none

module exec_wb_stage #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [2:0]        op_i,
  input  logic [WIDTH-1:0]  rs_data_i,
  input  logic [WIDTH-1:0]  rt_data_i,
  input  logic              cb_i,
  input  logic [ADDR_W-1:0] dest_addr_i,
  output logic              write_o,
  output logic [ADDR_W-1:0] write_addr_o,
  output logic [WIDTH-1:0]  write_data_o,
  output logic              write_CB_o,
  output logic              cb_data_o,
  output logic              busy_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_ADC = 3'd7;

  localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [0:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [ADDR_W-1:0]  mul_dest;

  logic               accept;
  logic [WIDTH:0]     sum;
  logic               lt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_cb;
  logic               alu_wr;
  logic               alu_wcb;

  assign issue_ready_o = (state == IDLE);
  assign busy_o        = (state == MUL);
  assign accept        = issue_valid_i && issue_ready_o;

  // The same adder serves ADD and ADC; carry-in only for ADC.
  assign sum = {1'b0, rs_data_i} + {1'b0, rt_data_i}
             + {{WIDTH{1'b0}}, (op_i == OP_ADC) & cb_i};
  assign lt  = (rs_data_i < rt_data_i);

  always_comb begin
    alu_res = sum[WIDTH-1:0];
    alu_cb  = sum[WIDTH];
    alu_wr  = 1'b1;
    alu_wcb = 1'b1;
    case (op_i)
      OP_SUB: begin
        alu_res = rs_data_i - rt_data_i;
        alu_cb  = lt;
      end
      OP_AND: begin
        alu_res = rs_data_i & rt_data_i;
        alu_wcb = 1'b0;
      end
      OP_OR: begin
        alu_res = rs_data_i | rt_data_i;
        alu_wcb = 1'b0;
      end
      OP_XOR: begin
        alu_res = rs_data_i ^ rt_data_i;
        alu_wcb = 1'b0;
      end
      OP_SLT: begin
        alu_wr = 1'b0;
        alu_cb = lt;
      end
      default: ;
    endcase
  end

  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      mul_dest     <= '0;
      write_o      <= 1'b0;
      write_CB_o   <= 1'b0;
      write_addr_o <= '0;
      write_data_o <= '0;
      cb_data_o    <= 1'b0;
    end else begin
      write_o    <= 1'b0;
      write_CB_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_i == OP_MUL) begin
              state    <= MUL;
              cnt      <= '0;
              acc      <= '0;
              mcand    <= {{WIDTH{1'b0}}, rs_data_i};
              mplier   <= rt_data_i;
              mul_dest <= dest_addr_i;
            end else begin
              write_o    <= alu_wr;
              write_CB_o <= alu_wcb;
              if (alu_wr) begin
                write_addr_o <= dest_addr_i;
                write_data_o <= alu_res;
              end
              if (alu_wcb) cb_data_o <= alu_cb;
            end
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          // Final step retires straight from the adder output.
          if (cnt == LAST) begin
            state        <= IDLE;
            cnt          <= '0;
            write_o      <= 1'b1;
            write_CB_o   <= 1'b1;
            write_addr_o <= mul_dest;
            write_data_o <= acc_next[WIDTH-1:0];
            cb_data_o    <= |acc_next[2*WIDTH-1:WIDTH];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exec_wb_stage.sv
// tb_exec_wb_stage: randomized + directed scoreboard bench for exec_wb_stage.
`default_nettype none

module tb_exec_wb_stage;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       issue_valid_i = 1'b0;
  logic       issue_ready_o;
  logic [2:0] op_i = '0;
  logic [7:0] rs_data_i = '0;
  logic [7:0] rt_data_i = '0;
  logic       cb_i = 1'b0;
  logic [2:0] dest_addr_i = '0;
  logic       write_o;
  logic [2:0] write_addr_o;
  logic [7:0] write_data_o;
  logic       write_CB_o;
  logic       cb_data_o;
  logic       busy_o;

  exec_wb_stage #(.WIDTH(8), .ADDR_W(3)) dut (
    .clk_i(clk), .reset_i(reset_i), .issue_valid_i(issue_valid_i),
    .issue_ready_o(issue_ready_o), .op_i(op_i), .rs_data_i(rs_data_i),
    .rt_data_i(rt_data_i), .cb_i(cb_i), .dest_addr_i(dest_addr_i),
    .write_o(write_o), .write_addr_o(write_addr_o), .write_data_o(write_data_o),
    .write_CB_o(write_CB_o), .cb_data_o(cb_data_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       w;
    logic [2:0] a;
    logic [7:0] d;
    logic       wcb;
    logic       cb;
  } exp_t;

  exp_t       q[$];
  logic [2:0] m_addr = '0;
  logic [7:0] m_data = '0;
  logic       m_cb = 1'b0;
  logic [7:0] rf[8];
  logic       rf_cb = 1'b0;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: plain integer arithmetic; tracks held output values.
  task automatic model_push(input int op, input int a, input int b, input int c,
                            input logic [2:0] d, input int when);
    exp_t e;
    int   s;
    int   res;
    bit   cbv;
    e.w = 1'b1; e.wcb = 1'b1; res = 0; cbv = 1'b0;
    case (op)
      0: begin s = a + b; res = s % 256; cbv = (s > 255); end
      1: begin res = (a - b + 256) % 256; cbv = (a < b); end
      2: begin res = a & b; e.wcb = 1'b0; end
      3: begin res = a | b; e.wcb = 1'b0; end
      4: begin res = a ^ b; e.wcb = 1'b0; end
      5: begin e.w = 1'b0; cbv = (a < b); end
      6: begin s = a * b; res = s % 256; cbv = (s > 255); end
      default: begin s = a + b + c; res = s % 256; cbv = (s > 255); end
    endcase
    if (e.w) begin m_addr = d; m_data = 8'(res); end
    if (e.wcb) m_cb = cbv;
    e.a = m_addr; e.d = m_data; e.cb = m_cb; e.cyc = when;
    q.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    bit   ok;
    if (!reset_i) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        check(1'b0, "missed_wb", 64'(cyc), 64'(q[0].cyc));
        void'(q.pop_front());
      end
      if (write_o || write_CB_o) begin
        if (write_o) rf[write_addr_o] = write_data_o;
        if (write_CB_o) rf_cb = cb_data_o;
        if (q.size() == 0) begin
          check(1'b0, "unexpected_wb", {write_o, write_addr_o, write_data_o, write_CB_o, cb_data_o}, 64'd0);
        end else begin
          e  = q.pop_front();
          ok = (e.cyc == cyc) && (e.w == write_o) && (e.wcb == write_CB_o) &&
               (e.a == write_addr_o) && (e.d == write_data_o) && (e.cb == cb_data_o);
          check(ok, "wb",
                {16'(cyc), write_o, write_addr_o, write_data_o, write_CB_o, cb_data_o},
                {16'(e.cyc), e.w, e.a, e.d, e.wcb, e.cb});
        end
      end
    end
  end

  task automatic check_reset_state(input string name);
    check(issue_ready_o && !busy_o, {name, "_ready_busy"}, {issue_ready_o, busy_o}, 64'b10);
    check(!write_o && !write_CB_o && !cb_data_o, {name, "_strobes"},
          {write_o, write_CB_o, cb_data_o}, 64'd0);
    check(write_addr_o == 3'd0 && write_data_o == 8'd0, {name, "_addr_data"},
          {write_addr_o, write_data_o}, 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      issue_valid_i = 1'b0;
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [2:0] d);
    int guard = 0;
    @(negedge clk);
    while (!issue_ready_o && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check(1'b0, "ready_timeout", 64'd0, 64'd1);
    op_i = op; rs_data_i = a; rt_data_i = b; cb_i = c; dest_addr_i = d;
    issue_valid_i = 1'b1;
    model_push(int'(op), int'(a), int'(b), int'(c), d, cyc + 1 + ((op == 3'd6) ? 8 : 0));
    @(posedge clk);
    #1;
    if (op == 3'd6) begin
      // Scribble on the inputs while busy: nothing may be accepted or re-latched.
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        check(busy_o && !issue_ready_o, "mul_busy", {busy_o, issue_ready_o}, 64'b10);
        op_i = (i == 0) ? 3'd0 : 3'($urandom_range(0, 7));
        rs_data_i = 8'($urandom); rt_data_i = 8'($urandom);
        cb_i = 1'($urandom); dest_addr_i = 3'($urandom);
        issue_valid_i = 1'b1;
      end
      @(negedge clk);
      issue_valid_i = 1'b0;
      check(!busy_o && issue_ready_o, "mul_done_ready", {busy_o, issue_ready_o}, 64'b01);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    send(3'd0, 8'hF0, 8'h20, 1'b0, 3'd2);
    send(3'd1, 8'h05, 8'h07, 1'b0, 3'd3);
    send(3'd5, 8'h07, 8'h05, 1'b0, 3'd4);
    send(3'd7, 8'h11, 8'h22, 1'b1, 3'd1);
    send(3'd0, 8'h3C, 8'hC4, 1'b0, 3'd6);
    send(3'd4, 8'hA5, 8'h0F, 1'b0, 3'd7);
    send(3'd2, 8'hF3, 8'h3E, 1'b0, 3'd0);
    idle(2);
    send(3'd6, 8'h13, 8'h0E, 1'b0, 3'd5);
    send(3'd6, 8'h0F, 8'h03, 1'b0, 3'd6);
    idle(3);

    // MUL aborted by reset four cycles after acceptance.
    @(negedge clk);
    op_i = 3'd6; rs_data_i = 8'hFF; rt_data_i = 8'hFF; dest_addr_i = 3'd7;
    issue_valid_i = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) begin
      @(negedge clk);
      issue_valid_i = 1'b0;
    end
    reset_i = 1'b1;
    @(posedge clk);
    #1 reset_i = 1'b0;
    m_addr = '0; m_data = '0; m_cb = 1'b0;
    @(negedge clk);
    check_reset_state("abort");
    idle(12);

    send(3'd0, 8'h11, 8'h00, 1'b0, 3'd0);
    send(3'd1, 8'h22, 8'h00, 1'b0, 3'd1);
    idle(3);
    check(rf[0] == 8'h11, "rf_reg0", 64'(rf[0]), 64'h11);
    check(rf[1] == 8'h22, "rf_reg1", 64'(rf[1]), 64'h22);
    check(rf_cb == 1'b0, "rf_cb", 64'(rf_cb), 64'd0);

    for (int i = 0; i < 80; i++) begin
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom), 3'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(15);
    check(q.size() == 0, "queue_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks, expected completion", n_checks);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/exec_wb_stage.md
Name: exec_wb_stage

Overview:
- Execute/writeback stage directly downstream of `regfile`.
- Consumes the `rs`/`rt` operand bytes and the condition bit read from `regfile`.
- Computes an 8-bit ALU result and drives `regfile`'s write port (`write_i`, `write_addr_i`, `write_data_i`, `write_CB_i`, `cb_data_i`).
- Single-cycle ops retire back-to-back; MUL is an iterative shift-add unit that stalls issue until it completes.

Parameters:
- WIDTH, 8, datapath width; also the MUL iteration count.
- ADDR_W, 3, register address width (8 registers).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- issue_valid_i  input  1  an instruction is presented this cycle.
- issue_ready_o  output  1  stage can accept an instruction this cycle.
- op_i  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 MUL, 7 ADC.
- rs_data_i  input  WIDTH  operand A (from regfile `rs_data_o`).
- rt_data_i  input  WIDTH  operand B (from regfile `rt_data_o`).
- cb_i  input  1  current condition bit (from regfile `cb_data_o`).
- dest_addr_i  input  ADDR_W  destination register.
- write_o  output  1  register write strobe (to regfile `write_i`).
- write_addr_o  output  ADDR_W  to regfile `write_addr_i`.
- write_data_o  output  WIDTH  to regfile `write_data_i`.
- write_CB_o  output  1  condition-bit write strobe (to regfile `write_CB_i`).
- cb_data_o  output  1  condition-bit value (to regfile `cb_data_i`).
- busy_o  output  1  a MUL is in progress.

Behaviour:
- Reset values:
  - write_o, write_CB_o, cb_data_o, busy_o = 0.
  - write_addr_o, write_data_o = 0.
  - issue_ready_o = 1 in the cycle after the reset edge; FSM to IDLE, iteration counter = 0.
- Accept condition:
  - An instruction is accepted on a rising edge where issue_valid_i && issue_ready_o.
  - op, operands, cb_i and dest are latched at acceptance; later input changes have no effect.
- FSM states:
  - IDLE: issue_ready_o = 1. Accept of ops 0-5 or 7 goes to IDLE and registers the writeback. Accept of op 6 goes to MUL.
  - MUL: issue_ready_o = 0, busy_o = 1. Performs one shift-add step per cycle for WIDTH cycles (counter 0..WIDTH-1). On the edge where counter = WIDTH-1, registers the writeback and returns to IDLE.
  - issue_valid_i while in MUL is ignored; no accept occurs.
- Latency:
  - ALU ops: write strobes high for exactly one cycle, in the cycle immediately after the accepting edge. Back-to-back accepts give consecutive one-cycle strobes.
  - MUL accepted at edge N: busy_o and ~issue_ready_o during cycles N+1..N+WIDTH. Strobes high during cycle N+WIDTH+1, in which issue_ready_o is already 1.
- Op semantics (A = rs, B = rt; all arithmetic unsigned; result truncated to WIDTH bits):
  - ADD: A+B. write_CB_o = 1, cb = carry out.
  - SUB: A-B. write_CB_o = 1, cb = borrow (A<B).
  - AND / OR / XOR: bitwise result. write_CB_o = 0.
  - SLT: write_o = 0, write_CB_o = 1, cb = (A<B).
  - MUL: low WIDTH bits of A*B. write_CB_o = 1, cb = (high WIDTH bits != 0).
  - ADC: A+B+cb_i. write_CB_o = 1, cb = carry out.
  - write_o = 1 for every op except SLT.
- Idle/no-strobe values: when write_o = 0, write_addr_o and write_data_o hold their previous values. When write_CB_o = 0, cb_data_o holds its previous value.
- Hazards:
  - No internal forwarding. The issuing stage must not read a register in the same cycle the write strobe for it is high; `regfile` updates on that edge.
  - ADC uses cb_i as sampled at accept.
- Reset mid-MUL: aborts the operation with no writeback; next cycle is IDLE with issue_ready_o = 1.
- Reset coincident with a writeback: reset wins; strobes are 0 in the following cycle.
- Dest register 0 is written like any other register.

Test Plan:
- ADD A=0xF0, B=0x20, dest=2 → next cycle write_o=1, addr=2, data=0x10; write_CB_o=1, cb=1.
- SUB A=0x05, B=0x07, dest=3 → data=0xFE, cb=1. Then SLT A=0x07, B=0x05 → write_o=0, write_CB_o=1, cb=0.
- ADC A=0x11, B=0x22, cb_i=1, dest=1 → data=0x34, cb=0. ADD/XOR/AND issued on 3 consecutive edges → 3 consecutive one-cycle strobes, issue_ready_o stays 1 throughout.
- MUL A=0x13, B=0x0E, dest=5 accepted at edge N:
  - busy_o=1 and issue_ready_o=0 for 8 cycles; an ADD presented during busy is not accepted.
  - Write strobe in cycle N+9 with data=0x0A, cb=1.
  - Then MUL 0x0F×0x03 → 0x2D, cb=0.
- MUL accepted, reset_i asserted 4 cycles later → no write or CB strobe ever occurs; next cycle issue_ready_o=1, busy_o=0, all outputs at reset values.
- Integration with `regfile`: ADD 0x11+0x00 to reg 0, then SUB 0x22-0x00 to reg 1 → regfile reads back 0x11 and 0x22, and `cb_data_o` reads 0.
